// File: rtl/draw_arbiter_if.sv
// Bundle between the draw requesters, the arbiter and the shared drawing datapath.
// master = arbiter side, slave = requester/datapath side.
`timescale 1ns/1ps
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 16
`endif

interface draw_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int INSTR_W  = `INSTRUCTION_WIDTH,
    parameter int RESULT_W = `RESULT_WIDTH
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*INSTR_W-1:0] req_instruction;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [RESULT_W-1:0]        rsp_result;
    logic                       rsp_timeout;
    logic                       start_dp;
    logic [INSTR_W-1:0]         instruction_dp;
    logic                       finished_dp;
    logic [RESULT_W-1:0]        result_dp;
    logic                       busy;
    logic [GW-1:0]              grant_id;

    modport master (
        input  req_valid, req_instruction, finished_dp, result_dp,
        output req_ready, rsp_valid, rsp_result, rsp_timeout, start_dp,
               instruction_dp, busy, grant_id
    );

    modport slave (
        output req_valid, req_instruction, finished_dp, result_dp,
        input  req_ready, rsp_valid, rsp_result, rsp_timeout, start_dp,
               instruction_dp, busy, grant_id
    );
endinterface

// File: rtl/draw_arbiter.sv
// Round-robin arbiter sharing one drawing datapath between NUM_REQ draw units,
// with a per-transaction watchdog that recovers from a hung datapath.
`timescale 1ns/1ps
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 16
`endif

module draw_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int INSTR_W        = `INSTRUCTION_WIDTH,
    parameter int RESULT_W       = `RESULT_WIDTH,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic           clock,
    input  logic           resetn,
    draw_arbiter_if.master bus
);
    localparam int GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_ACK  = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    logic [1:0]          state_reg;
    logic [GW-1:0]       rr_ptr_reg;
    logic [GW-1:0]       grant_id_reg;
    logic [WD_W-1:0]     wd_reg;
    logic [NUM_REQ-1:0]  req_ready_reg;
    logic [NUM_REQ-1:0]  rsp_valid_reg;
    logic [RESULT_W-1:0] rsp_result_reg;
    logic                rsp_timeout_reg;
    logic                start_dp_reg;
    logic [INSTR_W-1:0]  instruction_dp_reg;
    logic                busy_reg;

    logic [INSTR_W-1:0]  slot [NUM_REQ];
    logic [NUM_REQ-1:0]  upper_req;
    logic [GW-1:0]       win_id;
    logic                win_found;
    logic [GW-1:0]       ptr_next;
    logic                wd_expired;

    // upper_req keeps only requesters at or above the round-robin pointer
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign slot[gi]      = bus.req_instruction[gi*INSTR_W +: INSTR_W];
            assign upper_req[gi] = bus.req_valid[gi] && (GW'(gi) >= rr_ptr_reg);
        end
    endgenerate

    // Lowest set bit of upper_req wins; otherwise wrap to lowest set req_valid
    always_comb begin
        win_found = |bus.req_valid;
        win_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) win_id = GW'(i);
        end
        if (|upper_req) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (upper_req[i]) win_id = GW'(i);
            end
        end
    end

    assign ptr_next   = (grant_id_reg == GW'(NUM_REQ - 1)) ? '0 : grant_id_reg + 1'b1;
    assign wd_expired = (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg          <= IDLE;
            rr_ptr_reg         <= '0;
            grant_id_reg       <= '0;
            wd_reg             <= '0;
            req_ready_reg      <= '0;
            rsp_valid_reg      <= '0;
            rsp_result_reg     <= '0;
            rsp_timeout_reg    <= 1'b0;
            start_dp_reg       <= 1'b0;
            instruction_dp_reg <= '0;
            busy_reg           <= 1'b0;
        end else begin
            start_dp_reg  <= 1'b0;
            req_ready_reg <= '0;
            rsp_valid_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (bus.finished_dp && win_found) begin
                        grant_id_reg       <= win_id;
                        instruction_dp_reg <= slot[win_id];
                        start_dp_reg       <= 1'b1;
                        req_ready_reg      <= NUM_REQ'(1) << win_id;
                        busy_reg           <= 1'b1;
                        wd_reg             <= '0;
                        state_reg          <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    wd_reg <= wd_reg + 1'b1;
                    if (wd_expired) begin
                        rsp_valid_reg   <= NUM_REQ'(1) << grant_id_reg;
                        rsp_timeout_reg <= 1'b1;
                        rsp_result_reg  <= '0;
                        rr_ptr_reg      <= ptr_next;
                        busy_reg        <= 1'b0;
                        state_reg       <= IDLE;
                    end else if (!bus.finished_dp) begin
                        state_reg <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    wd_reg <= wd_reg + 1'b1;
                    // A completion on the expiry edge still counts as a normal finish
                    if (bus.finished_dp) begin
                        rsp_valid_reg   <= NUM_REQ'(1) << grant_id_reg;
                        rsp_timeout_reg <= 1'b0;
                        rsp_result_reg  <= bus.result_dp;
                        rr_ptr_reg      <= ptr_next;
                        busy_reg        <= 1'b0;
                        state_reg       <= IDLE;
                    end else if (wd_expired) begin
                        rsp_valid_reg   <= NUM_REQ'(1) << grant_id_reg;
                        rsp_timeout_reg <= 1'b1;
                        rsp_result_reg  <= '0;
                        rr_ptr_reg      <= ptr_next;
                        busy_reg        <= 1'b0;
                        state_reg       <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready      = req_ready_reg;
    assign bus.rsp_valid      = rsp_valid_reg;
    assign bus.rsp_result     = rsp_result_reg;
    assign bus.rsp_timeout    = rsp_timeout_reg;
    assign bus.start_dp       = start_dp_reg;
    assign bus.instruction_dp = instruction_dp_reg;
    assign bus.busy           = busy_reg;
    assign bus.grant_id       = grant_id_reg;
endmodule

// File: tb/tb_draw_arbiter.sv
// Directed bench for draw_arbiter: grants, fairness, blocked start, watchdog, async reset.
`timescale 1ns/1ps

module tb_draw_arbiter;
    localparam int NR = 4;
    localparam int IW = 32;
    localparam int RW = 16;
    localparam int TO = 16;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    draw_arbiter_if #(.NUM_REQ(NR), .INSTR_W(IW), .RESULT_W(RW)) bus ();

    draw_arbiter #(
        .NUM_REQ(NR), .INSTR_W(IW), .RESULT_W(RW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [IW-1:0] instr_tab [NR];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"},   bus.req_ready, 0);
        chk({tag, "_rsp_valid"},   bus.rsp_valid, 0);
        chk({tag, "_rsp_result"},  bus.rsp_result, 0);
        chk({tag, "_rsp_timeout"}, bus.rsp_timeout, 0);
        chk({tag, "_start_dp"},    bus.start_dp, 0);
        chk({tag, "_instr_dp"},    bus.instruction_dp, 0);
        chk({tag, "_busy"},        bus.busy, 0);
        chk({tag, "_grant_id"},    bus.grant_id, 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        chk_reset_outputs("reset");
        step();
        resetn = 1'b1;
    endtask

    // Called at the negedge where the grant for gid must already be visible.
    task automatic serve(input int gid, input int busy_cyc, input logic [RW-1:0] res, input bit drop);
        chk("grant_start_dp", bus.start_dp, 1);
        chk("grant_req_ready", bus.req_ready, 4'b0001 << gid);
        chk("grant_id", bus.grant_id, gid);
        chk("grant_instr_dp", bus.instruction_dp, instr_tab[gid]);
        chk("grant_busy", bus.busy, 1);
        if (drop) begin
            bus.req_valid[gid] = 1'b0;
            bus.req_instruction[gid*IW +: IW] = ~instr_tab[gid];
        end
        bus.finished_dp = 1'b0;
        for (int k = 0; k < busy_cyc; k++) begin
            step();
            if (k == 0) begin
                chk("start_pulse_end", bus.start_dp, 0);
                chk("ready_pulse_end", bus.req_ready, 0);
            end
        end
        bus.finished_dp = 1'b1;
        bus.result_dp   = res;
        step();
        chk("rsp_valid", bus.rsp_valid, 4'b0001 << gid);
        chk("rsp_result", bus.rsp_result, res);
        chk("rsp_timeout", bus.rsp_timeout, 0);
        chk("rsp_busy", bus.busy, 0);
        chk("instr_held", bus.instruction_dp, instr_tab[gid]);
        if (drop) bus.req_instruction[gid*IW +: IW] = instr_tab[gid];
        $display("txn grant=%0d busy=%0d result=0x%04h rsp_valid=%b timeout=%0b",
                 gid, busy_cyc, bus.rsp_result, bus.rsp_valid, bus.rsp_timeout);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        instr_tab[0] = 32'hA000_0000;
        instr_tab[1] = 32'hB111_1111;
        instr_tab[2] = 32'hC222_2222;
        instr_tab[3] = 32'hD333_3333;
        bus.req_valid   = '0;
        bus.finished_dp = 1'b1;
        bus.result_dp   = '0;
        for (int i = 0; i < NR; i++) bus.req_instruction[i*IW +: IW] = instr_tab[i];

        // Single request, exact grant latency, held result
        do_reset();
        bus.req_valid = 4'b0001;
        step();
        serve(0, 5, 16'h00A5, 1'b1);
        step();
        chk("rsp_pulse_end", bus.rsp_valid, 0);
        chk("rsp_result_held", bus.rsp_result, 16'h00A5);

        // Simultaneous requests 0 and 2
        do_reset();
        bus.req_valid = 4'b0101;
        step();
        serve(0, 2, 16'h1111, 1'b1);
        step();
        serve(2, 2, 16'h2222, 1'b1);

        // Fairness: all four requesting continuously
        do_reset();
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            serve(i % 4, 1 + (i % 3), 16'h3000 + 16'(i), 1'b0);
        end
        bus.req_valid = '0;

        // Blocked start while the datapath is not idle
        bus.finished_dp = 1'b0;
        bus.req_valid   = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("blocked_start_dp", bus.start_dp, 0);
            chk("blocked_req_ready", bus.req_ready, 0);
        end
        bus.finished_dp = 1'b1;
        step();
        serve(3, 3, 16'h4444, 1'b1);

        // Watchdog: datapath never drops finished_dp
        bus.req_valid = 4'b0010;
        step();
        chk("wd_start_dp", bus.start_dp, 1);
        chk("wd_grant_id", bus.grant_id, 1);
        bus.req_valid = '0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (k == 14) chk("wd_not_yet", bus.rsp_valid, 0);
        end
        step();
        chk("wd_rsp_valid", bus.rsp_valid, 4'b0010);
        chk("wd_rsp_timeout", bus.rsp_timeout, 1);
        chk("wd_rsp_result", bus.rsp_result, 0);
        chk("wd_busy", bus.busy, 0);
        $display("txn grant=1 watchdog rsp_valid=%b timeout=%0b result=0x%04h",
                 bus.rsp_valid, bus.rsp_timeout, bus.rsp_result);
        // Pointer moved to 2, so requester 0 wins over 1 after wrapping
        bus.req_valid = 4'b0011;
        step();
        serve(0, 2, 16'h5555, 1'b1);
        step();
        serve(1, 2, 16'h6666, 1'b1);

        // Asynchronous reset in WAIT_DONE
        bus.req_valid = 4'b0100;
        step();
        chk("mid_grant_id", bus.grant_id, 2);
        bus.req_valid   = '0;
        bus.finished_dp = 1'b0;
        step();
        step();
        #2;
        resetn = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        step();
        bus.req_valid = 4'b0110;
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_reset_no_start", bus.start_dp, 0);
            chk("post_reset_busy", bus.busy, 0);
        end
        bus.finished_dp = 1'b1;
        step();
        serve(1, 2, 16'h7777, 1'b1);
        bus.req_valid = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
